wb_periph_fabric: RTL

- Parametrised successor to the fixed single-peripheral hookup of the MCU top.
- Takes the core's split Wishbone read and write master ports and routes them to NUM_SLAVES peripheral slots by address decode.
- Arbitrates simultaneous read/write requests, enforces a per-transaction ack timeout, and records bus errors.
- Sits between PulseRain_Reindeer_core and the peripheral instances (UART, GPIO, timers, ...).

---
 rtl/wb_periph_fabric.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_periph_fabric.sv
// Wishbone peripheral fabric: split read/write masters to NUM_SLAVES slots.
// One transaction in flight, round-robin on collisions, ack timeout, sticky error log.
module wb_periph_fabric #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_BITS  = 8,
    parameter int DATA_W     = 32,
    parameter int SLOT_BITS  = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           rd_stb_i,
    input  logic [ADDR_BITS-1:0]           rd_adr_i,
    output logic [DATA_W-1:0]              rd_dat_o,
    output logic                           rd_ack_o,
    input  logic                           wr_stb_i,
    input  logic [DATA_W/8-1:0]            wr_sel_i,
    input  logic [ADDR_BITS-1:0]           wr_adr_i,
    input  logic [DATA_W-1:0]              wr_dat_i,
    output logic                           wr_ack_o,
    output logic [NUM_SLAVES-1:0]          s_stb_o,
    output logic                           s_we_o,
    output logic [DATA_W/8-1:0]            s_sel_o,
    output logic [ADDR_BITS-SLOT_BITS-1:0] s_adr_o,
    output logic [DATA_W-1:0]              s_dat_o,
    input  logic [NUM_SLAVES*DATA_W-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]          s_ack_i,
    output logic                           err_o,
    output logic [SLOT_BITS-1:0]           err_slot_o,
    output logic                           err_we_o,
    input  logic                           err_clr_i
);

    localparam int OFF_W = ADDR_BITS - SLOT_BITS;
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rr_q, rr_d;
    logic [SLOT_BITS-1:0]  slot_q, slot_d;
    logic [NUM_SLAVES-1:0] stb_q, stb_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [OFF_W-1:0]      adr_q, adr_d;
    logic [DATA_W-1:0]     dat_q, dat_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  wr_ack_q, wr_ack_d;
    logic [DATA_W-1:0]     rd_dat_q, rd_dat_d;
    logic                  err_q, err_d;
    logic [SLOT_BITS-1:0]  err_slot_q, err_slot_d;
    logic                  err_we_q, err_we_d;

    logic                  grant_wr;
    logic [ADDR_BITS-1:0]  req_adr;
    logic [SLOT_BITS-1:0]  req_slot;
    logic                  ack_hit;
    logic [DATA_W-1:0]     slv_dat;
    logic                  done;
    logic                  fail;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        slot_d     = slot_q;
        stb_d      = stb_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rd_ack_d   = 1'b0;
        wr_ack_d   = 1'b0;
        rd_dat_d   = rd_dat_q;
        err_slot_d = err_slot_q;
        err_we_d   = err_we_q;
        grant_wr   = 1'b0;
        req_adr    = rd_adr_i;
        req_slot   = req_adr[ADDR_BITS-1 -: SLOT_BITS];
        done       = 1'b0;
        fail       = 1'b0;

        // Only the latched slot's ack and data are visible
        ack_hit = 1'b0;
        slv_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (slot_q == SLOT_BITS'(k)) begin
                ack_hit = s_ack_i[k];
                slv_dat = s_dat_i[k*DATA_W +: DATA_W];
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rd_stb_i || wr_stb_i) begin
                    // rr_q == 0 means the write side wins a collision
                    grant_wr = wr_stb_i && (!rd_stb_i || !rr_q);
                    if (rd_stb_i && wr_stb_i) begin
                        rr_d = ~rr_q;
                    end
                    req_adr  = grant_wr ? wr_adr_i : rd_adr_i;
                    req_slot = req_adr[ADDR_BITS-1 -: SLOT_BITS];
                    slot_d   = req_slot;
                    adr_d    = req_adr[OFF_W-1:0];
                    we_d     = grant_wr;
                    sel_d    = grant_wr ? wr_sel_i : '0;
                    dat_d    = grant_wr ? wr_dat_i : '0;
                    cnt_d    = '0;
                    if ({1'b0, req_slot} >= (SLOT_BITS+1)'(NUM_SLAVES)) begin
                        fail = 1'b1;
                    end else begin
                        for (int k = 0; k < NUM_SLAVES; k++) begin
                            stb_d[k] = (req_slot == SLOT_BITS'(k));
                        end
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (ack_hit) begin
                    done = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done || fail) begin
            state_d  = ST_RESP;
            stb_d    = '0;
            wr_ack_d = we_d;
            rd_ack_d = !we_d;
            if (!we_d) begin
                rd_dat_d = fail ? '0 : slv_dat;
            end
        end

        // A new error in the clear cycle takes precedence
        err_d = err_q & ~err_clr_i;
        if (fail) begin
            err_d      = 1'b1;
            err_slot_d = slot_d;
            err_we_d   = we_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
            slot_q     <= '0;
            stb_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_ack_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_dat_q   <= '0;
            err_q      <= 1'b0;
            err_slot_q <= '0;
            err_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            slot_q     <= slot_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rd_ack_q   <= rd_ack_d;
            wr_ack_q   <= wr_ack_d;
            rd_dat_q   <= rd_dat_d;
            err_q      <= err_d;
            err_slot_q <= err_slot_d;
            err_we_q   <= err_we_d;
        end
    end

    assign rd_dat_o   = rd_dat_q;
    assign rd_ack_o   = rd_ack_q;
    assign wr_ack_o   = wr_ack_q;
    assign s_stb_o    = stb_q;
    assign s_we_o     = we_q;
    assign s_sel_o    = sel_q;
    assign s_adr_o    = adr_q;
    assign s_dat_o    = dat_q;
    assign err_o      = err_q;
    assign err_slot_o = err_slot_q;
    assign err_we_o   = err_we_q;

endmodule
